// File: rtl/ram_port_arb.sv
// Round-robin arbiter that lets NREQ requesters share one synchronous RAM port.
// After reset it zero-fills the RAM, then grants one access per cycle.
module ram_port_arb #(
  parameter int unsigned L2WIDTH = 3,
  parameter int unsigned L2SIZE  = 14,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned INIT    = 1,
  localparam int unsigned DW = 8 << L2WIDTH,
  localparam int unsigned BW = 1 << L2WIDTH,
  localparam int unsigned AW = L2SIZE - L2WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*BW-1:0]   req_bwe,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic                 init_done,
  output logic                 ram_enable,
  output logic [AW-1:0]        ram_addr,
  output logic [DW-1:0]        ram_wr_data,
  output logic                 ram_WE,
  output logic [BW-1:0]        ram_BWE,
  input  logic [DW-1:0]        ram_rd_data
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   icnt_q, icnt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic            init_done_q, init_done_d;

  logic [AW-1:0] addr_a  [NREQ];
  logic [DW-1:0] wdata_a [NREQ];
  logic [BW-1:0] bwe_a   [NREQ];

  logic            found_c;
  logic [PW-1:0]   win_c;
  logic [PW:0]     scan_c;
  logic [NREQ-1:0] ready_c;
  logic            ram_en_c;
  logic            ram_we_c;
  logic [AW-1:0]   ram_addr_c;
  logic [DW-1:0]   ram_wdata_c;
  logic [BW-1:0]   ram_bwe_c;

  // Unflatten requester buses.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i]  = req_addr[i*AW +: AW];
      wdata_a[i] = req_wdata[i*DW +: DW];
      bwe_a[i]   = req_bwe[i*BW +: BW];
    end
  end

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    scan_c  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_c = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (scan_c >= (PW+1)'(NREQ)) scan_c = scan_c - (PW+1)'(NREQ);
      if (!found_c && req_valid[scan_c[PW-1:0]]) begin
        found_c = 1'b1;
        win_c   = scan_c[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    icnt_d      = icnt_q;
    rr_ptr_d    = rr_ptr_q;
    init_done_d = init_done_q;
    rsp_valid_d = '0;
    ready_c     = '0;
    ram_en_c    = 1'b0;
    ram_we_c    = 1'b0;
    ram_addr_c  = '0;
    ram_wdata_c = '0;
    ram_bwe_c   = '0;
    case (state_q)
      S_INIT: begin
        ram_en_c   = 1'b1;
        ram_we_c   = 1'b1;
        ram_bwe_c  = '1;
        ram_addr_c = icnt_q;
        icnt_d     = icnt_q + AW'(1);
        if (icnt_q == '1) begin
          state_d     = S_RUN;
          init_done_d = 1'b1;
        end
      end
      default: begin
        if (found_c) begin
          ready_c[win_c]     = 1'b1;
          ram_en_c           = 1'b1;
          ram_we_c           = req_we[win_c];
          ram_addr_c         = addr_a[win_c];
          ram_wdata_c        = wdata_a[win_c];
          ram_bwe_c          = bwe_a[win_c];
          rsp_valid_d[win_c] = ~req_we[win_c];
          rr_ptr_d           = (win_c == PW'(NREQ-1)) ? '0 : win_c + PW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= (INIT != 0) ? S_INIT : S_RUN;
      icnt_q      <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      init_done_q <= (INIT == 0);
    end else begin
      state_q     <= state_d;
      icnt_q      <= icnt_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      init_done_q <= init_done_d;
    end
  end

  // Combinational outputs are held quiet while reset is asserted.
  assign req_ready   = reset ? '0 : ready_c;
  assign ram_enable  = ~reset & ram_en_c;
  assign ram_WE      = ~reset & ram_we_c;
  assign ram_addr    = ram_addr_c;
  assign ram_wr_data = ram_wdata_c;
  assign ram_BWE     = ram_bwe_c;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = ram_rd_data;
  assign init_done   = init_done_q;

endmodule

// File: tb/tb_ram_port_arb.sv
// Directed bench for ram_port_arb with a behavioural byte-enabled RAM model
// attached to the arbitrated port.
module tb_ram_port_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 11;
  localparam int unsigned DW   = 64;
  localparam int unsigned BW   = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid, req_ready, req_we, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ*BW-1:0] req_bwe;
  logic [DW-1:0]     rsp_data, ram_wr_data, ram_rd_data;
  logic              init_done, ram_enable, ram_WE;
  logic [AW-1:0]     ram_addr;
  logic [BW-1:0]     ram_BWE;

  logic [DW-1:0] mem [2048];
  int checks = 0;
  int errors = 0;

  localparam logic [63:0] DA = 64'ha0a1a2a3a4a5a6a7;
  localparam logic [63:0] DB = 64'hb0b1b2b3b4b5b6b7;
  logic [3:0]  exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [63:0] exp_dat [5] = '{DA, 64'h1134337855cd7790, 64'h0, DB, DA};

  ram_port_arb #(.L2WIDTH(3), .L2SIZE(14), .NREQ(4), .INIT(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_bwe(req_bwe),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .init_done(init_done),
    .ram_enable(ram_enable), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
    .ram_WE(ram_WE), .ram_BWE(ram_BWE), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with byte write enables; read data only updates on reads.
  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_WE) begin
        for (int b = 0; b < BW; b++)
          if (ram_BWE[b]) mem[ram_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
      end else begin
        ram_rd_data <= mem[ram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_req();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_bwe = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [BW-1:0] be);
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = wd;
    req_bwe[i*BW +: BW] = be;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 64'hdeadbeef0badf00d;
    ram_rd_data = '0;
    clr_req();
    reset = 1'b1;
    req_valid = 4'b1111;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(req_ready), 64'h0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_ram_enable", 64'(ram_enable), 64'h0);
    chk("reset_init_done", 64'(init_done), 64'h0);

    // 1: zero-fill, then read addr 5.
    clr_req();
    reset = 1'b0;
    #1;
    chk("init_enable", 64'(ram_enable), 64'h1);
    chk("init_we", 64'(ram_WE), 64'h1);
    chk("init_addr0", 64'(ram_addr), 64'h0);
    chk("init_ready", 64'(req_ready), 64'h0);
    repeat (2047) @(negedge clk);
    chk("init_done_2047", 64'(init_done), 64'h0);
    @(negedge clk);
    chk("init_done_2048", 64'(init_done), 64'h1);
    chk("idle_enable", 64'(ram_enable), 64'h0);
    set_req(0, 1'b0, 11'd5, '0, '0);
    #1;
    chk("s1_ready", 64'(req_ready), 64'h1);
    chk("s1_addr", 64'(ram_addr), 64'h5);
    @(negedge clk);
    chk("s1_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("s1_rsp_data", rsp_data, 64'h0);

    // 2: req1 full write, req2 read back.
    clr_req();
    set_req(1, 1'b1, 11'd1, 64'h12345678abcdef90, 8'hff);
    #1;
    chk("s2_wr_ready", 64'(req_ready), 64'h2);
    @(negedge clk);
    chk("s2_wr_no_rsp", 64'(rsp_valid), 64'h0);
    clr_req();
    set_req(2, 1'b0, 11'd1, '0, '0);
    #1;
    chk("s2_rd_ready", 64'(req_ready), 64'h4);
    @(negedge clk);
    chk("s2_rsp_valid", 64'(rsp_valid), 64'h4);
    chk("s2_rsp_data", rsp_data, 64'h12345678abcdef90);

    // 3: partial write by req3, fill addrs 10/11, read back via req3.
    clr_req();
    set_req(3, 1'b1, 11'd1, 64'h1122334455667788, 8'haa);
    @(negedge clk);
    clr_req();
    set_req(0, 1'b1, 11'd10, DA, 8'hff);
    @(negedge clk);
    clr_req();
    set_req(1, 1'b1, 11'd11, DB, 8'hff);
    @(negedge clk);
    clr_req();
    set_req(3, 1'b0, 11'd1, '0, '0);
    #1;
    chk("s3_ready", 64'(req_ready), 64'h8);
    @(negedge clk);
    chk("s3_rsp_valid", 64'(rsp_valid), 64'h8);
    chk("s3_rsp_data", rsp_data, 64'h1134337855cd7790);

    // 4: full contention, rr_ptr=0.
    clr_req();
    set_req(0, 1'b0, 11'd10, '0, '0);
    set_req(1, 1'b0, 11'd1, '0, '0);
    set_req(2, 1'b0, 11'd5, '0, '0);
    set_req(3, 1'b0, 11'd11, '0, '0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("s4_ready_%0d", c), 64'(req_ready), 64'(exp_rdy[c]));
      @(negedge clk);
      chk($sformatf("s4_rsp_valid_%0d", c), 64'(rsp_valid), 64'(exp_rdy[c]));
      chk($sformatf("s4_rsp_data_%0d", c), rsp_data, exp_dat[c]);
    end

    // 5: grant req1 (rr_ptr=2), then req0+req3 -> req3 first.
    clr_req();
    set_req(1, 1'b0, 11'd1, '0, '0);
    #1;
    chk("s5_ready_r1", 64'(req_ready), 64'h2);
    @(negedge clk);
    clr_req();
    set_req(0, 1'b0, 11'd10, '0, '0);
    set_req(3, 1'b0, 11'd11, '0, '0);
    #1;
    chk("s5_ready_r3", 64'(req_ready), 64'h8);
    @(negedge clk);
    chk("s5_rsp_r3", 64'(rsp_valid), 64'h8);
    chk("s5_data_r3", rsp_data, DB);
    req_valid[3] = 1'b0;
    #1;
    chk("s5_ready_r0", 64'(req_ready), 64'h1);
    @(negedge clk);
    chk("s5_rsp_r0", 64'(rsp_valid), 64'h1);
    chk("s5_data_r0", rsp_data, DA);

    // 6: reset during contention with a response pending.
    clr_req();
    set_req(0, 1'b0, 11'd10, '0, '0);
    set_req(1, 1'b0, 11'd1, '0, '0);
    set_req(2, 1'b0, 11'd5, '0, '0);
    set_req(3, 1'b0, 11'd11, '0, '0);
    #1;
    chk("s6_ready", 64'(req_ready), 64'h2);
    @(posedge clk);
    #2;
    chk("s6_rsp_pending", 64'(rsp_valid), 64'h2);
    reset = 1'b1;
    #1;
    chk("s6_rsp_cleared", 64'(rsp_valid), 64'h0);
    chk("s6_ready_gated", 64'(req_ready), 64'h0);
    chk("s6_enable_gated", 64'(ram_enable), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("s6_init_addr0", 64'(ram_addr), 64'h0);
    chk("s6_init_we", 64'(ram_WE), 64'h1);
    chk("s6_init_done_low", 64'(init_done), 64'h0);
    chk("s6_init_ready", 64'(req_ready), 64'h0);
    repeat (2048) @(negedge clk);
    chk("s6_init_done", 64'(init_done), 64'h1);
    #1;
    chk("s6_rrptr_reset", 64'(req_ready), 64'h1);
    @(negedge clk);
    chk("s6_rsp0", 64'(rsp_valid), 64'h1);
    chk("s6_data_addr10", rsp_data, 64'h0);
    #1;
    chk("s6_ready2", 64'(req_ready), 64'h2);
    @(negedge clk);
    chk("s6_rsp1", 64'(rsp_valid), 64'h2);
    chk("s6_data_addr1", rsp_data, 64'h0);

    clr_req();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
